// File: rtl/noc_ni_pkg.sv
// Shared constants and helpers for the NoC node network interface.
package noc_ni_pkg;

    // Destination field occupies the top DST_W bits of every flit.
    localparam int unsigned DST_W      = 4;
    // Widest flit the helpers can take; callers zero-extend into this width.
    localparam int unsigned FLIT_W_MAX = 64;

    // Credit counter update selected by {send, router credit return}.
    typedef enum logic [1:0] {
        CRD_IDLE   = 2'b00,
        CRD_RETURN = 2'b01,
        CRD_SEND   = 2'b10,
        CRD_BOTH   = 2'b11
    } crd_evt_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 32'd1;
            end
        end
        return res;
    endfunction

    // Extract {dst_cluster, dst_local} from a zero-extended flit of width flit_w.
    function automatic logic [DST_W-1:0] dst_of(input logic [FLIT_W_MAX-1:0] flit,
                                                 input int unsigned          flit_w);
        logic [FLIT_W_MAX-1:0] shifted;
        shifted = flit >> (flit_w - DST_W);
        return shifted[DST_W-1:0];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is a registered-array read (not fall-through).
module noc_sync_fifo
    import noc_ni_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees the slot the same cycle, so a push into a full FIFO succeeds alongside it.
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Storage and pointer update; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/noc_node_ni.sv
// Network interface between a router local port and a PE: credit-controlled
// injection, ejection buffering with credit return, destination check, counters.
module noc_node_ni
    import noc_ni_pkg::*;
#(
    parameter int unsigned FLIT_W      = 20,
    parameter int unsigned INJ_DEPTH   = 4,
    parameter int unsigned EJ_DEPTH    = 4,
    parameter int unsigned RTR_CREDITS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        my_cluster,
    input  logic [1:0]        my_local,
    input  logic [FLIT_W-1:0] pe_tx_data,
    input  logic              pe_tx_valid,
    output logic              pe_tx_ready,
    output logic [FLIT_W-1:0] inject,
    output logic              inject_valid,
    input  logic              rtr_credit,
    input  logic [FLIT_W-1:0] eject,
    input  logic              eject_valid,
    output logic              ej_credit,
    output logic [FLIT_W-1:0] pe_rx_data,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic [CNT_W-1:0]  tx_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic              misroute,
    output logic              credit_err
);

    localparam int unsigned       CRD_W   = clog2(RTR_CREDITS + 32'd1);
    localparam logic [CRD_W-1:0]  CRD_MAX = CRD_W'(RTR_CREDITS);

    // Injection path
    logic              inj_push_s;
    logic              inj_full_s;
    logic              inj_empty_s;
    logic [FLIT_W-1:0] inj_head_s;
    logic              send_s;

    // Ejection path
    logic              ej_push_s;
    logic              ej_pop_s;
    logic              ej_full_s;
    logic              ej_empty_s;
    logic              ej_drop_s;
    logic [FLIT_W-1:0] ej_head_s;
    logic [FLIT_W_MAX-1:0] eject_ext_s;
    logic              dst_bad_s;

    // Credit bookkeeping
    logic [CRD_W-1:0]  credit_q;
    logic [CRD_W-1:0]  credit_d;
    logic              credit_ovf_s;

    // Registered outputs
    logic [FLIT_W-1:0] inject_q;
    logic              inject_valid_q;
    logic              ej_credit_q;
    logic [CNT_W-1:0]  tx_count_q;
    logic [CNT_W-1:0]  rx_count_q;
    logic              misroute_q;
    logic              credit_err_q;

    assign pe_tx_ready = !inj_full_s;
    assign inj_push_s  = pe_tx_valid && !inj_full_s;
    assign send_s      = !inj_empty_s && (credit_q != '0);

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inj_push_s),
        .pop_i   (send_s),
        .data_i  (pe_tx_data),
        .head_o  (inj_head_s),
        .full_o  (inj_full_s),
        .empty_o (inj_empty_s)
    );

    assign ej_pop_s  = !ej_empty_s && pe_rx_ready;
    assign ej_push_s = eject_valid && (!ej_full_s || ej_pop_s);
    assign ej_drop_s = eject_valid && ej_full_s && !ej_pop_s;

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ej_push_s),
        .pop_i   (ej_pop_s),
        .data_i  (eject),
        .head_o  (ej_head_s),
        .full_o  (ej_full_s),
        .empty_o (ej_empty_s)
    );

    assign pe_rx_data  = ej_head_s;
    assign pe_rx_valid = !ej_empty_s;

    // Zero-extend the ejected flit so the shared destination helper can slice it.
    always_comb begin
        eject_ext_s             = '0;
        eject_ext_s[FLIT_W-1:0] = eject;
    end

    assign dst_bad_s = (dst_of(eject_ext_s, FLIT_W) != {my_cluster, my_local});

    // Next credit count; a return at the ceiling without a send is an overflow.
    always_comb begin
        credit_d     = credit_q;
        credit_ovf_s = 1'b0;
        case (crd_evt_e'({send_s, rtr_credit}))
            CRD_SEND: begin
                credit_d = credit_q - {{(CRD_W-1){1'b0}}, 1'b1};
            end
            CRD_RETURN: begin
                if (credit_q == CRD_MAX) begin
                    credit_ovf_s = 1'b1;
                end else begin
                    credit_d = credit_q + {{(CRD_W-1){1'b0}}, 1'b1};
                end
            end
            CRD_BOTH: begin
                credit_d = credit_q;
            end
            CRD_IDLE: begin
                credit_d = credit_q;
            end
            default: begin
                credit_d = credit_q;
            end
        endcase
    end

    // Credit counter, injection strobe, ejection credit pulse, counters and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q       <= CRD_MAX;
            inject_q       <= '0;
            inject_valid_q <= 1'b0;
            ej_credit_q    <= 1'b0;
            tx_count_q     <= '0;
            rx_count_q     <= '0;
            misroute_q     <= 1'b0;
            credit_err_q   <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            inject_valid_q <= send_s;
            inject_q       <= send_s ? inj_head_s : '0;
            ej_credit_q    <= ej_pop_s;
            if (send_s) begin
                tx_count_q <= tx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (ej_push_s) begin
                rx_count_q <= rx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (ej_push_s && dst_bad_s) begin
                misroute_q <= 1'b1;
            end
            if (credit_ovf_s || ej_drop_s) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    assign inject       = inject_q;
    assign inject_valid = inject_valid_q;
    assign ej_credit    = ej_credit_q;
    assign tx_count     = tx_count_q;
    assign rx_count     = rx_count_q;
    assign misroute     = misroute_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_node_ni.sv
// Directed bench for noc_node_ni: injection credits, ejection, destination check, overflow, async reset.
module tb_noc_node_ni;

    logic        clk;
    logic        rst;
    logic [1:0]  my_cluster;
    logic [1:0]  my_local;
    logic [19:0] pe_tx_data;
    logic        pe_tx_valid;
    logic        pe_tx_ready;
    logic [19:0] inject;
    logic        inject_valid;
    logic        rtr_credit;
    logic [19:0] eject;
    logic        eject_valid;
    logic        ej_credit;
    logic [19:0] pe_rx_data;
    logic        pe_rx_valid;
    logic        pe_rx_ready;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        misroute;
    logic        credit_err;

    int vec_cnt;
    int miscmp_cnt;

    logic [19:0] f_tx [7];
    logic [19:0] drain_exp [4];

    noc_node_ni #(
        .FLIT_W      (20),
        .INJ_DEPTH   (4),
        .EJ_DEPTH    (4),
        .RTR_CREDITS (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .my_cluster   (my_cluster),
        .my_local     (my_local),
        .pe_tx_data   (pe_tx_data),
        .pe_tx_valid  (pe_tx_valid),
        .pe_tx_ready  (pe_tx_ready),
        .inject       (inject),
        .inject_valid (inject_valid),
        .rtr_credit   (rtr_credit),
        .eject        (eject),
        .eject_valid  (eject_valid),
        .ej_credit    (ej_credit),
        .pe_rx_data   (pe_rx_data),
        .pe_rx_valid  (pe_rx_valid),
        .pe_rx_ready  (pe_rx_ready),
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .misroute     (misroute),
        .credit_err   (credit_err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check every output against its reset value.
    task automatic check_reset_outputs(input string pfx);
        check_vec({pfx, "_inject_valid"}, 32'(inject_valid), 32'd0);
        check_vec({pfx, "_inject"},       32'(inject),       32'd0);
        check_vec({pfx, "_ej_credit"},    32'(ej_credit),    32'd0);
        check_vec({pfx, "_pe_rx_valid"},  32'(pe_rx_valid),  32'd0);
        check_vec({pfx, "_pe_tx_ready"},  32'(pe_tx_ready),  32'd1);
        check_vec({pfx, "_tx_count"},     32'(tx_count),     32'd0);
        check_vec({pfx, "_rx_count"},     32'(rx_count),     32'd0);
        check_vec({pfx, "_misroute"},     32'(misroute),     32'd0);
        check_vec({pfx, "_credit_err"},   32'(credit_err),   32'd0);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int inj_seen;
        vec_cnt     = 0;
        miscmp_cnt  = 0;
        f_tx[0] = 20'h4ABCD; f_tx[1] = 20'h4ABCE; f_tx[2] = 20'h4ABCF;
        f_tx[3] = 20'h4ABD0; f_tx[4] = 20'h4ABD1; f_tx[5] = 20'h4ABD2;
        f_tx[6] = 20'h4ABD3;
        drain_exp[0] = 20'h9000B; drain_exp[1] = 20'h9000C;
        drain_exp[2] = 20'h9000D; drain_exp[3] = 20'h9000F;

        rst         = 1'b1;
        my_cluster  = 2'd2;
        my_local    = 2'd1;
        pe_tx_data  = 20'h0;
        pe_tx_valid = 1'b0;
        rtr_credit  = 1'b0;
        eject       = 20'h0;
        eject_valid = 1'b0;
        pe_rx_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;

        // Case 1: five pushes, four credits -> four back-to-back sends, fifth held.
        for (int i = 0; i < 5; i++) begin
            pe_tx_data  = f_tx[i];
            pe_tx_valid = 1'b1;
            tick();
            if (i == 0) begin
                check_vec("c1_first_lat", 32'(inject_valid), 32'd0);
            end else begin
                check_vec("c1_valid", 32'(inject_valid), 32'd1);
                check_vec("c1_data",  32'(inject),       32'(f_tx[i-1]));
            end
        end
        pe_tx_valid = 1'b0;
        tick();
        check_vec("c1_no_credit",   32'(inject_valid), 32'd0);
        check_vec("c1_tx_count",    32'(tx_count),     32'd4);
        check_vec("c1_tx_ready",    32'(pe_tx_ready),  32'd1);
        tick();
        check_vec("c1_held",        32'(inject_valid), 32'd0);

        // Case 2: one credit releases exactly one flit.
        rtr_credit = 1'b1;
        tick();
        rtr_credit = 1'b0;
        check_vec("c2_credit_edge", 32'(inject_valid), 32'd0);
        tick();
        check_vec("c2_one_valid",   32'(inject_valid), 32'd1);
        check_vec("c2_one_data",    32'(inject),       32'(f_tx[4]));
        tick();
        check_vec("c2_one_only",    32'(inject_valid), 32'd0);
        check_vec("c2_tx_count",    32'(tx_count),     32'd5);

        // Case 2b: send and credit return on the same edge leave the count unchanged.
        pe_tx_data  = f_tx[5];
        pe_tx_valid = 1'b1;
        rtr_credit  = 1'b1;
        tick();
        pe_tx_data  = f_tx[6];
        tick();
        pe_tx_valid = 1'b0;
        rtr_credit  = 1'b0;
        check_vec("c2_both_valid",  32'(inject_valid), 32'd1);
        check_vec("c2_both_data",   32'(inject),       32'(f_tx[5]));
        tick();
        check_vec("c2_kept_valid",  32'(inject_valid), 32'd1);
        check_vec("c2_kept_data",   32'(inject),       32'(f_tx[6]));
        tick();
        check_vec("c2_exhausted",   32'(inject_valid), 32'd0);
        check_vec("c2_tx_count2",   32'(tx_count),     32'd7);

        // Refill credits to the ceiling: no error expected.
        rtr_credit = 1'b1;
        repeat (4) tick();
        rtr_credit = 1'b0;
        check_vec("refill_no_err",  32'(credit_err),   32'd0);

        // Case 3: correctly addressed flit, pop, credit pulse one cycle later.
        eject       = 20'h90001;
        eject_valid = 1'b1;
        tick();
        eject_valid = 1'b0;
        check_vec("c3_rx_valid",    32'(pe_rx_valid),  32'd1);
        check_vec("c3_rx_data",     32'(pe_rx_data),   32'h90001);
        check_vec("c3_misroute",    32'(misroute),     32'd0);
        check_vec("c3_rx_count",    32'(rx_count),     32'd1);
        check_vec("c3_no_credit",   32'(ej_credit),    32'd0);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        check_vec("c3_ej_credit",   32'(ej_credit),    32'd1);
        check_vec("c3_rx_empty",    32'(pe_rx_valid),  32'd0);
        tick();
        check_vec("c3_credit_once", 32'(ej_credit),    32'd0);

        // Case 4: misrouted flit is flagged and still stored.
        eject       = 20'h30002;
        eject_valid = 1'b1;
        tick();
        eject_valid = 1'b0;
        check_vec("c4_misroute",    32'(misroute),     32'd1);
        check_vec("c4_rx_data",     32'(pe_rx_data),   32'h30002);
        check_vec("c4_rx_count",    32'(rx_count),     32'd2);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        tick();
        check_vec("c4_sticky",      32'(misroute),     32'd1);
        check_vec("c4_drained",     32'(pe_rx_valid),  32'd0);

        // Case 5: five ejects into a four-entry FIFO with no pops.
        for (int i = 0; i < 5; i++) begin
            eject       = 20'h9000A + 20'(i);
            eject_valid = 1'b1;
            tick();
            if (i == 3) begin
                check_vec("c5_full_no_err", 32'(credit_err), 32'd0);
            end
        end
        check_vec("c5_drop_err",    32'(credit_err),   32'd1);
        check_vec("c5_rx_count",    32'(rx_count),     32'd6);
        eject       = 20'h9000F;
        eject_valid = 1'b1;
        pe_rx_ready = 1'b1;
        tick();
        eject_valid = 1'b0;
        check_vec("c5_full_pushpop", 32'(rx_count),    32'd7);
        for (int k = 0; k < 4; k++) begin
            check_vec("c5_drain_valid", 32'(pe_rx_valid), 32'd1);
            check_vec("c5_drain_data",  32'(pe_rx_data),  32'(drain_exp[k]));
            tick();
        end
        pe_rx_ready = 1'b0;
        check_vec("c5_drain_empty", 32'(pe_rx_valid),  32'd0);

        // Case 6: async reset mid-cycle while both paths hold traffic.
        eject       = 20'h90005;
        eject_valid = 1'b1;
        tick();
        eject_valid = 1'b0;
        pe_tx_data  = 20'h12345;
        pe_tx_valid = 1'b1;
        tick();
        tick();
        check_vec("c6_pre_valid",   32'(inject_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("c6_async");
        pe_tx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_vec("c6_inj_empty",   32'(inject_valid), 32'd0);
        check_vec("c6_ej_empty",    32'(pe_rx_valid),  32'd0);

        // Extra credit at the ceiling after reset: error, count stays at four.
        rtr_credit = 1'b1;
        tick();
        rtr_credit = 1'b0;
        check_vec("c5_credit_ovf",  32'(credit_err),   32'd1);
        inj_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 5) begin
                pe_tx_data  = 20'h10000 + 20'(i);
                pe_tx_valid = 1'b1;
            end else begin
                pe_tx_valid = 1'b0;
            end
            tick();
            if (inject_valid) begin
                inj_seen++;
            end
        end
        check_vec("c6_credit_four", 32'(inj_seen),     32'd4);
        check_vec("c6_tx_count",    32'(tx_count),     32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
